// File: rtl/fft_fifo_pkg.sv
// Shared constants, state encoding and helpers for the FFT frame FIFO.
package fft_fifo_pkg;

   localparam int unsigned DEF_DATA_W    = 22;
   localparam int unsigned DEF_ADDR_W    = 9;
   localparam int unsigned DEF_FRAME_LEN = 64;

   // Frame release state: waiting for a whole frame, or streaming one out.
   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE   = 1'b0;
   localparam state_t ST_STREAM = 1'b1;

   // Ceiling log2, minimum result 0.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port sample store: synchronous write, asynchronous read.
module fifo_mem
   import fft_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              CLK,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   // Write port: store on the rising edge when enabled.
   always_ff @(posedge CLK) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fft_frame_fifo.sv
// Frame-gated FWFT FIFO: buffers samples and releases them in whole frames.
module fft_frame_fifo
   import fft_fifo_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned FRAME_LEN = DEF_FRAME_LEN
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] din,
   output logic              full,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   output logic              valid_o,
   output logic [DATA_W-1:0] dout,
   input  logic              rd_en,
   output logic              frame_start,
   output logic              frame_last
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned LW    = ADDR_W + 1;
   localparam int unsigned CW    = clog2(FRAME_LEN);

   localparam logic [LW-1:0] LVL_FRAME = LW'(FRAME_LEN);
   localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
   localparam logic [CW-1:0] BEAT_LAST = CW'(FRAME_LEN - 1);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [LW-1:0]     level_nxt;
   logic [CW-1:0]     beat;
   logic [CW-1:0]     beat_nxt;
   state_t            state;
   state_t            state_nxt;
   logic              push;
   logic              pop;
   logic              clr;

   assign clr         = RST | flush;
   assign full        = (level == LVL_FULL);
   assign push        = wr_en & ~full;
   assign valid_o     = (state == ST_STREAM);
   assign pop         = rd_en & valid_o;
   assign level_nxt   = level + LW'(push) - LW'(pop);
   assign frame_start = valid_o & (beat == '0);
   assign frame_last  = valid_o & (beat == BEAT_LAST);

   fifo_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .CLK   (CLK),
      .we    (push & ~clr),
      .waddr (wr_ptr),
      .wdata (din),
      .raddr (rd_ptr),
      .rdata (dout)
   );

   // Pointer, level and sticky overflow bookkeeping.
   always_ff @(posedge CLK) begin
      if (clr) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
         level <= level_nxt;
         if (wr_en & full) overflow <= 1'b1;
      end
   end

   // Frame release decision; at the last beat the projected level decides
   // whether the next frame follows without a bubble.
   always_comb begin
      state_nxt = state;
      beat_nxt  = beat;
      case (state)
         ST_IDLE: begin
            if (level >= LVL_FRAME) state_nxt = ST_STREAM;
         end
         default: begin
            if (pop) begin
               if (beat == BEAT_LAST) begin
                  beat_nxt = '0;
                  if (level_nxt < LVL_FRAME) state_nxt = ST_IDLE;
               end else begin
                  beat_nxt = beat + CW'(1);
               end
            end
         end
      endcase
   end

   // State and beat counter registers.
   always_ff @(posedge CLK) begin
      if (clr) begin
         state <= ST_IDLE;
         beat  <= '0;
      end else begin
         state <= state_nxt;
         beat  <= beat_nxt;
      end
   end

endmodule
